// File: rtl/conv_window_gen.sv
// Streaming 3x3 zero-padded window generator (pad=1, stride=1) for a raster stream of
// (row, col, channel-group) words. Two rotating row buffers hold the previous rows.
module conv_window_gen #(
  parameter int DATA_W    = 64,
  parameter int MAX_DEPTH = 4096,
  parameter int DIM_W     = 10,
  parameter int GRP_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [DIM_W-1:0]                cfg_width,
  input  logic [DIM_W-1:0]                cfg_height,
  input  logic [GRP_W-1:0]                cfg_groups,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [0:2][0:2][DATA_W-1:0]     pixels,
  output logic                            valid_out,
  output logic                            last_channel,
  output logic                            busy,
  output logic                            done
);
  localparam int ADDR_W = $clog2(MAX_DEPTH);
  localparam int HIST_D = 1 << GRP_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_COL_FLUSH, S_ROW_FLUSH} state_t;
  typedef logic [0:2][DATA_W-1:0]      col_t;   // one window column, [i] = window row
  typedef logic [0:2][0:2][DATA_W-1:0] win_t;

  state_t             r_state, w_state_nxt;
  logic [DIM_W-1:0]   r_cfg_w, r_cfg_h, r_row, r_col;
  logic [GRP_W-1:0]   r_cfg_g, r_grp;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_wsel, r_fin, r_done, r_busy, r_valid, r_last;
  win_t               r_pixels;

  logic [DATA_W-1:0]  r_buf0 [MAX_DEPTH];
  logic [DATA_W-1:0]  r_buf1 [MAX_DEPTH];
  col_t               r_hist1 [HIST_D];     // column c-1 per group
  col_t               r_hist2 [HIST_D];     // column c-2 per group

  logic               w_accept, w_grp_last, w_col_last, w_row_last, w_row_end, w_step, w_emit;
  logic [ADDR_W-1:0]  w_addr_l, w_addr_r;
  logic [DATA_W-1:0]  w_old_l, w_old_m, w_old_r, w_prv_l, w_prv_m, w_prv_r;
  col_t               w_new_col;
  win_t               w_cols, w_pixels;
  logic [0:2]         w_rv, w_cv;

  assign w_accept   = (r_state == S_RUN) && in_valid;
  assign w_grp_last = (r_grp == r_cfg_g - GRP_W'(1));
  assign w_col_last = (r_col == r_cfg_w - DIM_W'(1));
  assign w_row_last = (r_row == r_cfg_h - DIM_W'(1));
  assign w_row_end  = w_accept && w_grp_last && w_col_last;
  assign w_step     = w_accept || (r_state == S_ROW_FLUSH);

  // r_wsel selects the buffer being overwritten (row r-2); the other holds row r-1.
  assign w_addr_l  = r_addr - ADDR_W'(r_cfg_g);
  assign w_addr_r  = r_addr + ADDR_W'(r_cfg_g);
  assign w_old_l   = r_wsel ? r_buf1[w_addr_l] : r_buf0[w_addr_l];
  assign w_old_m   = r_wsel ? r_buf1[r_addr]   : r_buf0[r_addr];
  assign w_old_r   = r_wsel ? r_buf1[w_addr_r] : r_buf0[w_addr_r];
  assign w_prv_l   = r_wsel ? r_buf0[w_addr_l] : r_buf1[w_addr_l];
  assign w_prv_m   = r_wsel ? r_buf0[r_addr]   : r_buf1[r_addr];
  assign w_prv_r   = r_wsel ? r_buf0[w_addr_r] : r_buf1[w_addr_r];
  assign w_new_col = {w_old_m, w_prv_m, in_data};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (start) w_state_nxt = S_RUN;
      S_RUN:       if (w_row_end) begin
                     if (r_row != '0)     w_state_nxt = S_COL_FLUSH;
                     else if (w_row_last) w_state_nxt = S_ROW_FLUSH;
                   end
      S_COL_FLUSH: if (w_grp_last) w_state_nxt = w_row_last ? S_ROW_FLUSH : S_RUN;
      S_ROW_FLUSH: if (w_grp_last && w_col_last) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Padding comes only from these row/column range flags, never from buffer contents.
  always_comb begin
    w_emit   = 1'b0;
    w_cols   = '0;
    w_rv     = '0;
    w_cv     = '0;
    w_pixels = '0;
    case (r_state)
      S_RUN: if (w_accept && r_row != '0 && r_col != '0) begin
        w_emit = 1'b1;
        w_cols = {r_hist2[r_grp], r_hist1[r_grp], w_new_col};
        w_rv   = {r_row > DIM_W'(1), 1'b1, 1'b1};
        w_cv   = {r_col > DIM_W'(1), 1'b1, 1'b1};
      end
      S_COL_FLUSH: begin
        w_emit = 1'b1;
        w_cols = {r_hist2[r_grp], r_hist1[r_grp], col_t'('0)};
        w_rv   = {r_row > DIM_W'(1), 1'b1, 1'b1};
        w_cv   = {r_cfg_w > DIM_W'(1), 1'b1, 1'b0};
      end
      S_ROW_FLUSH: begin
        w_emit = 1'b1;
        w_cols = {{w_old_l, w_prv_l, {DATA_W{1'b0}}},
                  {w_old_m, w_prv_m, {DATA_W{1'b0}}},
                  {w_old_r, w_prv_r, {DATA_W{1'b0}}}};
        w_rv   = {r_cfg_h > DIM_W'(1), 1'b1, 1'b0};
        w_cv   = {r_col != '0, 1'b1, !w_col_last};
      end
      default: ;
    endcase
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w_pixels[i][j] = (w_rv[i] && w_cv[j]) ? w_cols[j][i] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_w <= '0; r_cfg_h <= '0; r_cfg_g <= '0;
      r_row   <= '0; r_col   <= '0; r_grp   <= '0;
      r_addr  <= '0; r_wsel  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_cfg_w <= cfg_width; r_cfg_h <= cfg_height; r_cfg_g <= cfg_groups;
        r_row   <= '0; r_col <= '0; r_grp <= '0; r_addr <= '0;
      end
    end else if (r_state == S_COL_FLUSH) begin
      r_grp <= w_grp_last ? '0 : r_grp + GRP_W'(1);
      if (w_grp_last && !w_row_last) r_row <= r_row + DIM_W'(1);
    end else if (w_step) begin
      r_grp  <= w_grp_last ? '0 : r_grp + GRP_W'(1);
      r_addr <= (w_grp_last && w_col_last) ? '0 : r_addr + ADDR_W'(1);
      if (w_grp_last) r_col <= w_col_last ? '0 : r_col + DIM_W'(1);
      if (w_row_end) begin
        r_wsel <= ~r_wsel;
        if (r_row == '0 && !w_row_last) r_row <= DIM_W'(1);
      end
    end
  end

  // NOTE: storage has no reset; out-of-image taps are masked by coordinates instead.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hist2[r_grp] <= r_hist1[r_grp];
      r_hist1[r_grp] <= w_new_col;
      if (r_wsel) r_buf1[r_addr] <= in_data;
      else        r_buf0[r_addr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pixels <= '0; r_valid <= 1'b0; r_last <= 1'b0;
      r_fin    <= 1'b0; r_done <= 1'b0; r_busy <= 1'b0;
    end else begin
      r_valid <= w_emit;
      r_last  <= w_emit && w_grp_last;
      if (w_emit) r_pixels <= w_pixels;
      r_fin   <= (r_state == S_ROW_FLUSH) && w_grp_last && w_col_last;
      r_done  <= r_fin;
      if (r_fin) r_busy <= 1'b0;
      if (r_state == S_IDLE && start) r_busy <= 1'b1;
    end
  end

  assign in_ready     = (r_state == S_RUN);
  assign pixels       = r_pixels;
  assign valid_out    = r_valid;
  assign last_channel = r_last;
  assign busy         = r_busy;
  assign done         = r_done;
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: frame table + window model, spot values and
// flush/done timing, mid-frame reset and ignored mid-frame start.
module tb_conv_window_gen;
  localparam logic [63:0] WORD_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] WORD_B = 64'hFEDC_BA98_7654_3210;

  logic                  clk = 1'b0;
  logic                  rst, start, in_valid;
  logic [9:0]            cfg_width, cfg_height;
  logic [7:0]            cfg_groups;
  logic [63:0]           in_data;
  logic                  in_ready, valid_out, last_channel, busy, done;
  logic [0:2][0:2][63:0] pixels;

  conv_window_gen dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_groups(cfg_groups),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .pixels(pixels), .valid_out(valid_out), .last_channel(last_channel),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int w; int h; int g; int pat; int gap; int inj; int abort_at; int exp_n; int exp_lat; } frame_t;
  typedef struct { int frame; int idx; int i; int j; logic [63:0] val; } spot_t;
  typedef struct { logic [0:2][0:2][63:0] pix; logic lc; int cyc; } win_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     done_cnt = 0;
  int     done_cyc = 0;
  int     zrun = 0;
  win_t   win_q[$];
  int     runs_q[$];
  frame_t frames[7];
  spot_t  spots[13];

  task automatic check(input string name, input logic [599:0] act, input logic [599:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] word(input int pat, input int y, input int x, input int g);
    case (pat)
      0:       return {8{8'(4 * y + x + 1)}};
      1:       return {8{8'(16 * g + 3 * y + x)}};
      default: return (g == 0) ? WORD_A : WORD_B;
    endcase
  endfunction

  function automatic logic [63:0] px(input frame_t f, input int y, input int x, input int g);
    if (y < 0 || y >= f.h || x < 0 || x >= f.w) return 64'd0;
    return word(f.pat, y, x, g);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out) win_q.push_back('{pix: pixels, lc: last_channel, cyc: cyc});
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (!busy) zrun <= 0;
    else if (!in_ready) zrun <= zrun + 1;
    else if (zrun != 0) begin
      runs_q.push_back(zrun);
      zrun <= 0;
    end
  end

  task automatic run_frame(input frame_t f, input int fi);
    int idx = 0, budget = 0, acc_edge = 0, d0, n = 0, total, exp_runs, y, x, g;
    bit took, injected = 0;
    logic [0:2][0:2][63:0] ep;
    total = f.w * f.h * f.g;
    win_q.delete();
    runs_q.delete();
    d0 = done_cnt;
    cfg_width = 10'(f.w); cfg_height = 10'(f.h); cfg_groups = 8'(f.g);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < total && budget < 4000) begin
      y = idx / (f.w * f.g); x = (idx / f.g) % f.w; g = idx % f.g;
      in_data  = word(f.pat, y, x, g);
      in_valid = ($urandom_range(99) >= f.gap);
      if (f.inj != 0 && idx == 5 && !injected) begin
        start = 1'b1; cfg_width = 10'd2; injected = 1;
      end
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      budget++;
      if (took) begin
        acc_edge = cyc;
        idx++;
        if (idx == f.abort_at) break;
      end
    end
    in_valid = 1'b0;
    check($sformatf("f%0d_words_accepted", fi), idx, (f.abort_at > 0) ? f.abort_at : total);
    if (f.abort_at > 0) return;
    @(negedge clk);
    check($sformatf("f%0d_in_ready_after_last", fi), in_ready, 1'b0);
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check($sformatf("f%0d_done_pulses", fi), done_cnt - d0, 1);
    check($sformatf("f%0d_window_count", fi), win_q.size(), f.exp_n);
    for (int k = 0; k < f.exp_n && k < win_q.size(); k++) begin
      g = k % f.g; x = (k / f.g) % f.w; y = k / (f.w * f.g);
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          ep[i][j] = px(f, y - 1 + i, x - 1 + j, g);
      check($sformatf("f%0d_win%0d", fi, k), {win_q[k].lc, win_q[k].pix}, {(g == f.g - 1), ep});
    end
    if (win_q.size() > 0)
      check($sformatf("f%0d_done_after_last_win", fi), done_cyc - win_q[$].cyc, 1);
    check($sformatf("f%0d_done_latency", fi), done_cyc - acc_edge, f.exp_lat);
    exp_runs = (f.h >= 2) ? f.h - 2 : 0;
    check($sformatf("f%0d_col_flush_count", fi), runs_q.size(), exp_runs);
    foreach (runs_q[r]) check($sformatf("f%0d_col_flush_len%0d", fi, r), runs_q[r], f.g);
    foreach (spots[s]) begin
      if (spots[s].frame == fi) begin
        if (spots[s].idx < win_q.size())
          check($sformatf("f%0d_spot_w%0d_%0d%0d", fi, spots[s].idx, spots[s].i, spots[s].j),
                win_q[spots[s].idx].pix[spots[s].i][spots[s].j], spots[s].val);
        else
          check($sformatf("f%0d_spot_missing_w%0d", fi, spots[s].idx), win_q.size(), spots[s].idx + 1);
      end
    end
  endtask

  initial begin
    //           w  h  g pat gap inj abort exp_n lat
    frames[0] = '{4, 4, 1, 0,  0, 0,  0,   16,  6};
    frames[1] = '{3, 2, 3, 1,  0, 0,  0,   18, 13};
    frames[2] = '{1, 1, 2, 2,  0, 0,  0,    2,  3};
    frames[3] = '{4, 4, 1, 0, 30, 0,  0,   16,  6};
    frames[4] = '{4, 4, 1, 0,  0, 0, 10,   16,  6};
    frames[5] = '{4, 4, 1, 0,  0, 0,  0,   16,  6};
    frames[6] = '{4, 4, 1, 0,  0, 1,  0,   16,  6};
    spots = '{
      '{0,  0, 1, 1, {8{8'd1}}},  '{0,  0, 1, 2, {8{8'd2}}},
      '{0,  0, 2, 1, {8{8'd5}}},  '{0,  0, 2, 2, {8{8'd6}}},
      '{0,  0, 0, 1, 64'd0},      '{0,  0, 1, 0, 64'd0},
      '{0, 15, 0, 0, {8{8'd11}}}, '{0, 15, 1, 1, {8{8'd16}}},
      '{0, 15, 2, 1, 64'd0},      '{1, 14, 1, 1, {8{8'd36}}},
      '{1, 14, 0, 0, {8{8'd32}}}, '{2,  0, 1, 1, WORD_A},
      '{2,  1, 1, 1, WORD_B}
    };

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_width = '0; cfg_height = '0; cfg_groups = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", {pixels, valid_out, last_channel, busy, done, in_ready}, '0);

    for (int fi = 0; fi < 7; fi++) begin
      run_frame(frames[fi], fi);
      if (frames[fi].abort_at > 0) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midframe_reset_state", {pixels, valid_out, last_channel, busy, done, in_ready}, '0);
        repeat (2) @(negedge clk);
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
